rc4_message_checker: RTL and testbench

- Consumes the output of the RC4 decrypt stage for each candidate key.
- Scans the decrypted-message RAM byte by byte and confirms every byte is lowercase ASCII 'a'..'z' or space.
- Reports the result to the secret-key search FSM on Checker_Finish / Decrypt_Valid. The search FSM then either stops or advances to the next key.
- Aborts the scan on the first illegal byte so that key search throughput is maximised.

---
 rtl/rc4_message_checker_if.sv | 34 +++
 rtl/rc4_message_checker.sv | 90 +++++++++
 tb/tb_rc4_message_checker.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_message_checker_if.sv
// Handshake and RAM-read bundle between the key-search FSM (master) and the
// decrypted-message checker (slave).
interface rc4_message_checker_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) ();
    logic              Start;
    logic [ADDR_W-1:0] Ram_Addr;
    logic [DATA_W-1:0] Ram_Q;
    logic              Busy;
    logic              Checker_Finish;
    logic              Decrypt_Valid;
    logic [ADDR_W-1:0] Bad_Index;

    modport master (
        output Start,
        output Ram_Q,
        input  Ram_Addr,
        input  Busy,
        input  Checker_Finish,
        input  Decrypt_Valid,
        input  Bad_Index
    );

    modport slave (
        input  Start,
        input  Ram_Q,
        output Ram_Addr,
        output Busy,
        output Checker_Finish,
        output Decrypt_Valid,
        output Bad_Index
    );
endinterface

// File: rtl/rc4_message_checker.sv
// Scans the decrypted-message RAM and reports whether every byte is 'a'..'z' or space,
// aborting on the first illegal byte.
module rc4_message_checker #(
    parameter int unsigned MSG_LEN = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 8
) (
    input logic                clk,
    input logic                rst,
    rc4_message_checker_if.slave bus
);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MSG_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetAddr,
        StWaitRead,
        StCheck,
        StDoneValid,
        StDoneInvalid
    } state_e;

    state_e            state;
    logic [ADDR_W-1:0] ram_addr;
    logic [ADDR_W-1:0] bad_index;
    logic              busy;
    logic              finish;
    logic              valid;
    logic              byte_legal;

    // Only consumed in StCheck, so it never reaches an output combinationally.
    assign byte_legal = (bus.Ram_Q == DATA_W'(8'h20)) ||
                        ((bus.Ram_Q >= DATA_W'(8'h61)) && (bus.Ram_Q <= DATA_W'(8'h7A)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            ram_addr  <= '0;
            bad_index <= '0;
            busy      <= 1'b0;
            finish    <= 1'b0;
            valid     <= 1'b0;
        end else begin
            case (state)
                StIdle, StDoneValid, StDoneInvalid: begin
                    if (bus.Start) begin
                        ram_addr  <= '0;
                        bad_index <= '0;
                        busy      <= 1'b1;
                        finish    <= 1'b0;
                        valid     <= 1'b0;
                        state     <= StSetAddr;
                    end
                end
                StSetAddr: begin
                    state <= StWaitRead;
                end
                StWaitRead: begin
                    state <= StCheck;
                end
                StCheck: begin
                    if (!byte_legal) begin
                        bad_index <= ram_addr;
                        busy      <= 1'b0;
                        finish    <= 1'b1;
                        valid     <= 1'b0;
                        state     <= StDoneInvalid;
                    end else if (ram_addr == LastAddr) begin
                        busy   <= 1'b0;
                        finish <= 1'b1;
                        valid  <= 1'b1;
                        state  <= StDoneValid;
                    end else begin
                        ram_addr <= ram_addr + 1'b1;
                        state    <= StSetAddr;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign bus.Ram_Addr       = ram_addr;
    assign bus.Busy           = busy;
    assign bus.Checker_Finish = finish;
    assign bus.Decrypt_Valid  = valid;
    assign bus.Bad_Index      = bad_index;
endmodule

// File: tb/tb_rc4_message_checker.sv
// Randomized scoreboard bench for rc4_message_checker: stimulus predicts each scan's
// result from the message contents, a negedge monitor compares when Checker_Finish rises.
module tb_rc4_message_checker;
    localparam int unsigned MSG_LEN = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rc4_message_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rc4_message_checker #(
        .MSG_LEN(MSG_LEN),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Synchronous-read message RAM
    logic [7:0] ram [MSG_LEN];
    always @(posedge clk) bus.Ram_Q <= ram[bus.Ram_Addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit valid;
        int bad;
        int done_edge;
        int max_addr;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit legal(input logic [7:0] b);
        return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    function automatic exp_t predict(input int start_edge);
        exp_t e;
        e.valid     = 1'b1;
        e.bad       = 0;
        e.done_edge = start_edge + 3 * MSG_LEN;
        e.max_addr  = MSG_LEN - 1;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (!legal(ram[i])) begin
                e.valid     = 1'b0;
                e.bad       = i;
                e.done_edge = start_edge + 3 * i + 3;
                e.max_addr  = i;
                break;
            end
        end
        return e;
    endfunction

    function automatic logic [7:0] rand_legal();
        logic [7:0] b;
        if ($urandom_range(0, 5) == 0) b = 8'h20;
        else b = 8'h61 + 8'($urandom_range(0, 25));
        return b;
    endfunction

    function automatic logic [7:0] rand_illegal();
        logic [7:0] b;
        b = 8'($urandom);
        while (legal(b)) b = 8'($urandom);
        return b;
    endfunction

    task automatic fill_legal();
        for (int i = 0; i < MSG_LEN; i++) ram[i] = rand_legal();
    endtask

    // Start is held for 'hold' accepting-or-busy edges; returns the accepting edge number.
    task automatic issue_start(input int hold, input bit expect_result, output int start_edge);
        @(negedge clk);
        bus.Start = 1'b1;
        @(posedge clk);
        #1;
        start_edge = cyc;
        check("accept_busy", bus.Busy, 1);
        check("accept_finish_clear", bus.Checker_Finish, 0);
        if (expect_result) sb.push_back(predict(start_edge));
        repeat (hold - 1) @(posedge clk);
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.Checker_Finish && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            check("done_timeout", 1, 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_scan(input int hold);
        int s;
        issue_start(hold, 1'b1, s);
        wait_done();
    endtask

    // Monitor
    bit   prev_finish = 1'b0;
    int   max_addr    = 0;
    exp_t got;
    always @(negedge clk) begin
        if (rst) begin
            prev_finish = 1'b0;
            max_addr    = 0;
        end else begin
            if (bus.Busy && int'(bus.Ram_Addr) > max_addr) max_addr = int'(bus.Ram_Addr);
            if (bus.Checker_Finish && !prev_finish) begin
                if (sb.size() == 0) begin
                    check("unexpected_finish", 1, 0);
                end else begin
                    got = sb.pop_front();
                    check("decrypt_valid", bus.Decrypt_Valid, got.valid);
                    check("bad_index", bus.Bad_Index, got.bad);
                    check("finish_edge", cyc, got.done_edge);
                    check("max_ram_addr", max_addr, got.max_addr);
                    check("busy_at_done", bus.Busy, 0);
                end
                max_addr = 0;
            end
            prev_finish = bus.Checker_Finish;
        end
    end

    initial begin
        int s;
        logic [7:0] bnd [4];
        bus.Start = 1'b0;
        for (int i = 0; i < MSG_LEN; i++) ram[i] = 8'h61;
        #2;
        check("reset_outputs", {bus.Ram_Addr, bus.Busy, bus.Checker_Finish,
                                bus.Decrypt_Valid, bus.Bad_Index}, 0);
        #20;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_outputs", {bus.Busy, bus.Checker_Finish, bus.Decrypt_Valid}, 0);

        // All 'a'
        run_scan(1);
        // Illegal first byte
        ram[0] = 8'h41;
        run_scan(1);
        // Boundary legal bytes throughout
        for (int i = 0; i < MSG_LEN; i++) ram[i] = (i % 3 == 0) ? 8'h20 : (i % 3 == 1) ? 8'h61 : 8'h7A;
        run_scan(1);
        // Boundary illegal bytes at the last index
        bnd[0] = 8'h1F; bnd[1] = 8'h21; bnd[2] = 8'h60; bnd[3] = 8'h7B;
        for (int j = 0; j < 4; j++) begin
            fill_legal();
            ram[MSG_LEN-1] = bnd[j];
            run_scan(1);
        end
        // Start held during the scan must not restart it
        fill_legal();
        ram[5] = 8'h7B;
        run_scan(10);
        // Restart straight from DONE_INVALID with a now-legal message
        fill_legal();
        ram[3] = 8'h41;
        run_scan(1);
        fill_legal();
        run_scan(1);

        // Asynchronous reset mid-scan
        fill_legal();
        issue_start(1, 1'b0, s);
        repeat (40) @(posedge clk);
        #1;
        check("busy_before_reset", bus.Busy, 1);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {bus.Ram_Addr, bus.Busy, bus.Checker_Finish,
                                      bus.Decrypt_Valid, bus.Bad_Index}, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_idle", {bus.Busy, bus.Checker_Finish}, 0);
        run_scan(1);

        // Random messages
        for (int r = 0; r < 20; r++) begin
            fill_legal();
            if ($urandom_range(0, 1) == 1) ram[$urandom_range(0, MSG_LEN - 1)] = rand_illegal();
            run_scan(($urandom_range(0, 3) == 0) ? 4 : 1);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
